dm_copy_engine: RTL and testbench
=================================

# dm_copy_engine

Initiator-side block-transfer engine for the `DM` data memory. It owns the DM port set (`address`, `write_data`, `mem_write`, `mem_read`, `read_data`) and runs block copies or block fills, one byte at a time. It sits between the control logic and `DM`. Commands come from a single-cycle `start` strobe with latched operands, and completion is signalled by a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, default 8: DM address width.
- `DATA_W`, default 8: DM data width.
- `LEN_W`, default 9: transfer length width. Legal lengths are 0..256.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  1  0 = copy, 1 = fill.
- `src_addr`  in  ADDR_W  copy source base address.
- `dst_addr`  in  ADDR_W  destination base address.
- `length`  in  LEN_W  number of bytes to transfer.
- `fill_data`  in  DATA_W  byte written in fill mode.
- `abort`  in  1  terminates the active transfer.
- `busy`  out  1  high while a transfer is active.
- `done`  out  1  one-cycle completion pulse.
- `bytes_done`  out  LEN_W  count of bytes written so far in the current or last transfer.
- `address`  out  ADDR_W  to DM.
- `write_data`  out  DATA_W  to DM.
- `mem_write`  out  1  to DM.
- `mem_read`  out  1  to DM.
- `read_data`  in  DATA_W  from DM; valid in the cycle after `mem_read` was high.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- On `start` in IDLE:
  - Latch `op`, `src_addr`, `dst_addr`, `length`, `fill_data`.
  - Clear `bytes_done`.
  - Next state: READ if copy and length>0; WRITE if fill and length>0; DONE if length=0.
  - Operand changes while busy have no effect.
- READ:
  - Drive `mem_read`=1, `address`=src pointer.
  - Next state: CAPTURE.
- CAPTURE:
  - Drive `mem_read`=0, `mem_write`=0.
  - Register `read_data` into the data buffer.
  - Next state: WRITE.
- WRITE:
  - Drive `mem_write`=1, `address`=dst pointer.
  - `write_data` = buffer (copy) or latched `fill_data` (fill).
  - At the edge: increment `bytes_done` and both pointers.
  - Next state: DONE if `bytes_done`+1 = length; otherwise READ (copy) or WRITE (fill).
- DONE:
  - `done`=1, `busy`=0.
  - Next state: IDLE. `start` is ignored in DONE.
- Pointer arithmetic is modulo 2^ADDR_W: address 255 + 1 wraps to 0.
- Copy always runs ascending. Overlapping regions with dst > src propagate already-copied bytes; this is the intended behaviour.
- `mem_read` and `mem_write` are never high in the same cycle.
- Abort:
  - `abort`=1 in READ, CAPTURE, or WRITE sends the FSM to IDLE at the next edge.
  - No `done` pulse is generated.
  - `bytes_done` holds the bytes completed, including a write issued in the same cycle as the abort.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in IDLE: the command is rejected.
- Reset:
  - Asynchronous assertion from any state forces IDLE and clears all outputs to 0: `busy`, `done`, `bytes_done`, `address`, `write_data`, `mem_write`, `mem_read`.
  - Any partial transfer is lost.
- In IDLE, `address` and `write_data` hold their last driven values; `mem_read` and `mem_write` are 0.

## Timing
- All outputs are registered.
- `start` is sampled at edge E0; the first READ (or WRITE) cycle begins at E0.
- Copy: 3 cycles per byte. For N>0, `busy` is high for 3N cycles, and `done` is high in cycle 3N+1 after E0.
- Fill: 1 cycle per byte. `busy` is high for N cycles, and `done` is high in cycle N+1.
- length=0: `done` is high in the first cycle after E0, and `busy` never rises.
- The earliest next `start` is accepted in the IDLE cycle after DONE.
- DM contract: a write takes effect at the rising edge that ends a cycle with `mem_write`=1. `read_data` is stable throughout CAPTURE.

## Test plan
- Copy: preload DM[10..12] = AA, BB, CC; start op=0, src=10, dst=20, len=3 → DM[20..22] = AA, BB, CC; `done` pulses once, 10 cycles after `start`; `bytes_done`=3.
- Fill: op=1, dst=40, len=5, fill_data=5A → DM[40..44] = 5A; `done` 6 cycles after `start`; `mem_read` never asserted.
- Zero length: len=0 → `done` the next cycle; no DM access; `busy` stays 0.
- Wrap-around: copy src=254, dst=100, len=4 with DM[254]=01, DM[255]=02, DM[0]=03, DM[1]=04 → DM[100..103] = 01..04.
- Abort: fill len=10, assert `abort` in the 4th WRITE cycle → `bytes_done`=4, DM[dst+4] untouched, no `done`; a new `start` two cycles later runs normally.
- Reset mid-copy: pull `reset` low during CAPTURE → all outputs 0 immediately; after release, IDLE and `start` is accepted.

Source files
------------

// File: rtl/dm_copy_engine.sv
// Byte-serial block copy/fill engine driving the DM port set.
// Copy takes READ -> CAPTURE -> WRITE per byte; fill issues back-to-back WRITEs.
module dm_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bytes_done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_op;
  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_fill;
  logic              r_busy;
  logic              r_done;
  logic [LEN_W-1:0]  r_bytes_done;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_write_data;
  logic              r_mem_write;
  logic              r_mem_read;

  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;

  assign w_src_nxt = r_src_ptr + ADDR_W'(1);
  assign w_dst_nxt = r_dst_ptr + ADDR_W'(1);
  assign w_cnt_nxt = r_bytes_done + LEN_W'(1);

  // Outputs are registered: each transition loads the outputs of the state it enters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op         <= 1'b0;
      r_src_ptr    <= '0;
      r_dst_ptr    <= '0;
      r_len        <= '0;
      r_fill       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bytes_done <= '0;
      r_address    <= '0;
      r_write_data <= '0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_op         <= op;
            r_src_ptr    <= src_addr;
            r_dst_ptr    <= dst_addr;
            r_len        <= length;
            r_fill       <= fill_data;
            r_bytes_done <= '0;
            if (length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (op) begin
              r_state      <= S_WRITE;
              r_busy       <= 1'b1;
              r_mem_write  <= 1'b1;
              r_address    <= dst_addr;
              r_write_data <= fill_data;
            end else begin
              r_state    <= S_READ;
              r_busy     <= 1'b1;
              r_mem_read <= 1'b1;
              r_address  <= src_addr;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            // write_data doubles as the copy buffer
            r_state      <= S_WRITE;
            r_mem_write  <= 1'b1;
            r_address    <= r_dst_ptr;
            r_write_data <= read_data;
          end
        end
        S_WRITE: begin
          // The write in this cycle lands at this edge, so it counts even under abort.
          r_bytes_done <= w_cnt_nxt;
          r_src_ptr    <= w_src_nxt;
          r_dst_ptr    <= w_dst_nxt;
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_cnt_nxt == r_len) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_op) begin
            r_mem_write  <= 1'b1;
            r_address    <= w_dst_nxt;
            r_write_data <= r_fill;
          end else begin
            r_state    <= S_READ;
            r_mem_read <= 1'b1;
            r_address  <= w_src_nxt;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign bytes_done = r_bytes_done;
  assign address    = r_address;
  assign write_data = r_write_data;
  assign mem_write  = r_mem_write;
  assign mem_read   = r_mem_read;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Scoreboard bench for dm_copy_engine: expected DM writes and done pulses are
// queued by the stimulus and consumed by a negedge monitor.
module tb_dm_copy_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] length = '0;
  logic [7:0] fill_data = '0;
  logic       abort = 1'b0;
  logic       busy, done, mem_write, mem_read;
  logic [8:0] bytes_done;
  logic [7:0] address, write_data;
  logic [7:0] read_data = '0;

  logic [7:0] mem [256];

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [8:0] cnt; int lat; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  dm_copy_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
    .bytes_done(bytes_done), .address(address), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // DM model
  always @(posedge clock) begin
    if (mem_write) mem[address] <= write_data;
    if (mem_read) read_data <= mem[address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (reset) begin
      if (mem_write && mem_read) begin
        checks++; errors++;
        $display("FAIL rw_exclusive: got both high expected one");
      end
      if (mem_write) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", address, write_data);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", 32'(address), 32'(e.a));
          check("wr_data", 32'(write_data), 32'(e.d));
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got pulse expected none");
        end else begin
          dn_t e;
          e = dn_q.pop_front();
          check("done_bytes", 32'(bytes_done), 32'(e.cnt));
          check("done_latency", 32'(cyc - t_start), 32'(e.lat));
          check("done_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic go(input logic o, input logic [7:0] s, input logic [7:0] d,
                    input logic [8:0] n, input logic [7:0] f);
    @(negedge clock);
    op = o; src_addr = s; dst_addr = d; length = n; fill_data = f;
    start = 1'b1;
    t_start = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a; e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic push_dn(input logic [8:0] c, input int l);
    dn_t e;
    e.cnt = c; e.lat = l;
    dn_q.push_back(e);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[10] = 8'hAA; mem[11] = 8'hBB; mem[12] = 8'hCC;
    mem[254] = 8'h01; mem[255] = 8'h02; mem[0] = 8'h03; mem[1] = 8'h04;
    mem[64] = 8'hEE;

    idle(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bytes", 32'(bytes_done), 0);
    check("rst_addr", 32'(address), 0);
    check("rst_wdata", 32'(write_data), 0);
    check("rst_mwr", 32'(mem_write), 0);
    check("rst_mrd", 32'(mem_read), 0);
    reset = 1'b1;
    idle(2);

    // Copy 10..12 -> 20..22
    push_wr(8'd20, 8'hAA); push_wr(8'd21, 8'hBB); push_wr(8'd22, 8'hCC);
    push_dn(9'd3, 10);
    go(1'b0, 8'd10, 8'd20, 9'd3, 8'h00);
    idle(12);
    check("copy_m20", 32'(mem[20]), 32'hAA);
    check("copy_m22", 32'(mem[22]), 32'hCC);
    check("copy_bytes", 32'(bytes_done), 3);

    // Fill 40..44 with 5A, no reads
    for (int i = 0; i < 5; i++) push_wr(8'(40 + i), 8'h5A);
    push_dn(9'd5, 6);
    go(1'b1, 8'd0, 8'd40, 9'd5, 8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      seen = seen | mem_read;
      @(negedge clock);
    end
    check("fill_noread", 32'(seen), 0);
    check("fill_m40", 32'(mem[40]), 32'h5A);
    check("fill_m44", 32'(mem[44]), 32'h5A);
    check("fill_m45", 32'(mem[45]), 32'h00);

    // Zero length
    push_dn(9'd0, 1);
    go(1'b0, 8'd10, 8'd90, 9'd0, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | busy | mem_read | mem_write;
      @(negedge clock);
    end
    check("zero_quiet", 32'(seen), 0);
    check("zero_bytes", 32'(bytes_done), 0);

    // Address wrap 254..1 -> 100..103
    push_wr(8'd100, 8'h01); push_wr(8'd101, 8'h02);
    push_wr(8'd102, 8'h03); push_wr(8'd103, 8'h04);
    push_dn(9'd4, 13);
    go(1'b0, 8'd254, 8'd100, 9'd4, 8'h00);
    idle(15);
    check("wrap_m100", 32'(mem[100]), 32'h01);
    check("wrap_m103", 32'(mem[103]), 32'h04);

    // Abort in 4th WRITE of a 10-byte fill
    for (int i = 0; i < 4; i++) push_wr(8'(60 + i), 8'h33);
    go(1'b1, 8'd0, 8'd60, 9'd10, 8'h33);
    idle(3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_bytes", 32'(bytes_done), 4);
    check("abort_busy", 32'(busy), 0);
    idle(1);
    check("abort_m63", 32'(mem[63]), 32'h33);
    check("abort_m64", 32'(mem[64]), 32'hEE);
    push_wr(8'd70, 8'h77); push_wr(8'd71, 8'h77);
    push_dn(9'd2, 3);
    go(1'b1, 8'd0, 8'd70, 9'd2, 8'h77);
    idle(4);
    check("post_abort_m71", 32'(mem[71]), 32'h77);

    // abort together with start in IDLE rejects the command
    abort = 1'b1;
    go(1'b1, 8'd0, 8'd80, 9'd1, 8'h99);
    abort = 1'b0;
    check("rej_busy", 32'(busy), 0);
    idle(3);
    check("rej_m80", 32'(mem[80]), 32'h00);

    // Reset during CAPTURE
    go(1'b0, 8'd10, 8'd30, 9'd3, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_addr", 32'(address), 0);
    check("mrst_wdata", 32'(write_data), 0);
    check("mrst_mrd", 32'(mem_read), 0);
    check("mrst_bytes", 32'(bytes_done), 0);
    @(negedge clock);
    reset = 1'b1;
    idle(1);
    push_wr(8'd50, 8'hC3);
    push_dn(9'd1, 2);
    go(1'b1, 8'd0, 8'd50, 9'd1, 8'hC3);
    idle(3);
    check("mrst_m50", 32'(mem[50]), 32'hC3);
    check("mrst_m30", 32'(mem[30]), 32'h00);

    check("wr_q_empty", 32'(wr_q.size()), 0);
    check("dn_q_empty", 32'(dn_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
